// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State and owner encodings match the CPU-side common definitions.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD   = 64;
  localparam int DEF_INST_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one fixed-latency
// single-port memory, returning read data to the winning requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD     = DEF_WORD,
  parameter int INST_W   = DEF_INST_W,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [WORD-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [INST_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD-1:0]   d_addr,
  input  logic [WORD-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD-1:0]   d_rdata,
  output logic [WORD-1:0]   mem_addr,
  output logic [WORD-1:0]   mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [WORD-1:0]   mem_rdata
);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic              we_q;
  logic [WORD-1:0]   addr_q;
  logic [WORD-1:0]   wdata_q;
  logic [CNT_W-1:0]  starve_q;
  logic [INST_W-1:0] if_rdata_q;
  logic [WORD-1:0]   d_rdata_q;
  logic              pick_d;
  logic              accept;
  logic              cnt_zero;
  logic              capture;

  // Data normally wins; fetch is forced through once it has lost MAX_WAIT times
  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    pick_d  = d_req & ~(if_req & (starve_q == CNT_W'(MAX_WAIT)));
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          d_gnt   = pick_d;
          if_gnt  = ~pick_d;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: if (cnt_zero) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign accept  = if_gnt | d_gnt;
  assign capture = (state_q == ST_ACCESS) && cnt_zero;

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .dec      (state_q == ST_ACCESS),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept edge: latch the winning command for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= d_gnt ? OWN_D : OWN_IF;
      we_q    <= d_gnt & d_we;
      addr_q  <= d_gnt ? d_addr : if_addr;
      wdata_q <= d_gnt ? d_wdata : '0;
    end
  end

  // Starvation only accumulates while fetch is actually waiting in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (!if_req || if_gnt) begin
        starve_q <= '0;
      end else if (d_gnt && starve_q != CNT_W'(MAX_WAIT)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Last access cycle: read data is valid and is captured for the owner only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (owner_q == OWN_IF) begin
        if_rdata_q <= addr_q[2] ? mem_rdata[2*INST_W-1:INST_W] : mem_rdata[INST_W-1:0];
      end else if (!we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state_q == ST_ACCESS) & ~we_q;
  assign mem_wr    = (state_q == ST_ACCESS) & we_q;
  assign if_rvalid = (state_q == ST_RESP) & (owner_q == OWN_IF);
  assign d_rvalid  = (state_q == ST_RESP) & (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, MAX_WAIT=3).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD     (64),
    .INST_W   (32),
    .MEM_LAT  (2),
    .MAX_WAIT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Hold both requests until n grants are seen; pat bit i = 1 means data wins grant i
  task automatic collect_grants(input int n, input logic [7:0] pat, input string tag);
    int got = 0;
    int cyc = 0;
    if_req  = 1'b1;
    if_addr = 64'h20;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 64'h80;
    while (got < n && cyc < n * 4 + 8) begin
      smp();
      check({tag, "_both_gnt"}, 64'(if_gnt & d_gnt), 64'h0);
      if (if_gnt || d_gnt) begin
        check($sformatf("%s_grant%0d", tag, got), 64'(d_gnt), 64'(pat[got]));
        got++;
      end
      tick();
      cyc++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check({tag, "_grant_count"}, 64'(got), 64'(n));
    repeat (4) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;

    smp();
    check("rst_if_gnt",    64'(if_gnt), 64'h0);
    check("rst_d_gnt",     64'(d_gnt), 64'h0);
    check("rst_if_rvalid", 64'(if_rvalid), 64'h0);
    check("rst_d_rvalid",  64'(d_rvalid), 64'h0);
    check("rst_if_rdata",  64'(if_rdata), 64'h0);
    check("rst_d_rdata",   d_rdata, 64'h0);
    check("rst_mem_addr",  mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_mem_rd",    64'(mem_rd), 64'h0);
    check("rst_mem_wr",    64'(mem_wr), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fetch at 0x104: upper half of the memory word
    if_req    = 1'b1;
    if_addr   = 64'h104;
    mem_rdata = 64'hAAAA_BBBB_1111_2222;
    smp();
    check("fetch_if_gnt", 64'(if_gnt), 64'h1);
    check("fetch_d_gnt",  64'(d_gnt), 64'h0);
    tick();
    if_req = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      smp();
      check($sformatf("fetch_mem_rd_t%0d", i), 64'(mem_rd), 64'h1);
      check($sformatf("fetch_mem_wr_t%0d", i), 64'(mem_wr), 64'h0);
      check($sformatf("fetch_addr_t%0d", i), mem_addr, 64'h104);
      check($sformatf("fetch_early_rvalid_t%0d", i), 64'(if_rvalid), 64'h0);
      tick();
    end
    smp();
    check("fetch_if_rvalid", 64'(if_rvalid), 64'h1);
    check("fetch_if_rdata",  64'(if_rdata), 64'hAAAA_BBBB);
    check("fetch_resp_rd",   64'(mem_rd), 64'h0);
    check("fetch_d_rvalid",  64'(d_rvalid), 64'h0);
    tick();
    smp();
    check("fetch_rvalid_pulse", 64'(if_rvalid), 64'h0);
    tick();

    // Store 0xDEAD to 0x40
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h40;
    d_wdata = 64'hDEAD;
    smp();
    check("store_d_gnt", 64'(d_gnt), 64'h1);
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      smp();
      check($sformatf("store_mem_wr_t%0d", i), 64'(mem_wr), 64'h1);
      check($sformatf("store_mem_rd_t%0d", i), 64'(mem_rd), 64'h0);
      check($sformatf("store_wdata_t%0d", i), mem_wdata, 64'hDEAD);
      check($sformatf("store_addr_t%0d", i), mem_addr, 64'h40);
      tick();
    end
    smp();
    check("store_d_rvalid",  64'(d_rvalid), 64'h1);
    check("store_if_rvalid", 64'(if_rvalid), 64'h0);
    check("store_resp_wr",   64'(mem_wr), 64'h0);
    check("store_resp_rd",   64'(mem_rd), 64'h0);
    tick();

    // Both held: D, D, D, IF, D, D, D, IF
    collect_grants(8, 8'b0111_0111, "arb");

    // Fetch withdrawn during a data access, then idle clears starvation
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h10;
    if_req = 1'b1;
    if_addr = 64'h30;
    smp();
    check("wd_d_gnt",  64'(d_gnt), 64'h1);
    check("wd_if_gnt", 64'(if_gnt), 64'h0);
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      smp();
      check($sformatf("wd_no_if_gnt_t%0d", i), 64'(if_gnt), 64'h0);
      tick();
    end
    smp();
    tick();
    collect_grants(4, 8'b0000_0111, "post_wd");

    // Load 0x1234 then a fetch: d_rdata must hold
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 64'h8;
    mem_rdata = 64'h1234;
    smp();
    check("ld_d_gnt", 64'(d_gnt), 64'h1);
    tick();
    d_req = 1'b0;
    tick();
    tick();
    smp();
    check("ld_d_rvalid", 64'(d_rvalid), 64'h1);
    check("ld_d_rdata",  d_rdata, 64'h1234);
    tick();
    if_req    = 1'b1;
    if_addr   = 64'h0;
    mem_rdata = 64'h5555_6666_7777_8888;
    smp();
    check("ld_fetch_gnt", 64'(if_gnt), 64'h1);
    tick();
    if_req = 1'b0;
    tick();
    tick();
    smp();
    check("ld_fetch_rvalid", 64'(if_rvalid), 64'h1);
    check("ld_fetch_rdata",  64'(if_rdata), 64'h7777_8888);
    check("ld_hold_d_rdata", d_rdata, 64'h1234);
    tick();

    // Reset in the first access cycle drops the load
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h18;
    smp();
    check("rstx_d_gnt", 64'(d_gnt), 64'h1);
    tick();
    d_req = 1'b0;
    #2;
    check("rstx_mem_rd_before", 64'(mem_rd), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rstx_mem_rd_async", 64'(mem_rd), 64'h0);
    check("rstx_mem_addr",     mem_addr, 64'h0);
    check("rstx_d_rdata",      d_rdata, 64'h0);
    smp();
    check("rstx_d_rvalid_in_rst", 64'(d_rvalid), 64'h0);
    tick();
    tick();
    rst_n     = 1'b1;
    if_req    = 1'b1;
    if_addr   = 64'h10;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    smp();
    check("rstx_if_gnt_first", 64'(if_gnt), 64'h1);
    check("rstx_d_rvalid_0",   64'(d_rvalid), 64'h0);
    tick();
    if_req = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      smp();
      check($sformatf("rstx_d_rvalid_t%0d", i), 64'(d_rvalid), 64'h0);
      tick();
    end
    smp();
    check("rstx_if_rvalid", 64'(if_rvalid), 64'h1);
    check("rstx_if_rdata",  64'(if_rdata), 64'h89AB_CDEF);
    check("rstx_d_rvalid_end", 64'(d_rvalid), 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the CPU's instruction-fetch requester and data load/store requester.
- Arbitrates between the two, sequences the fixed-latency memory access, and returns read data to the winning requester.
- Sits between the CPU (instruction and data bus sides) and the memory model. Enables the multicycle/stalling CPU variants to run on a single memory.

Parameters:
- WORD, 64, data and address width (from common.vh `WORD).
- INST_W, 32, instruction width (from common.vh `INST_SIZE).
- MEM_LAT, 2, cycles the memory command is held; legal range 1..15.
- MAX_WAIT, 3, consecutive lost arbitrations before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  WORD  fetch byte address, 4-byte aligned.
- if_gnt  out  1  fetch accepted, 1-cycle pulse.
- if_rvalid  out  1  fetch data valid, 1-cycle pulse.
- if_rdata  out  INST_W  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WORD  data byte address, 8-byte aligned.
- d_wdata  in  WORD  store data.
- d_gnt  out  1  data accepted, 1-cycle pulse.
- d_rvalid  out  1  load data valid, or store complete; 1-cycle pulse.
- d_rdata  out  WORD  load data.
- mem_addr  out  WORD  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  WORD  memory read data; valid in the last command cycle.

Behaviour:
- Clocking and reset: one clock clk; reset is asynchronous and active-low, rst_n.
- Reset:
  - State IDLE; starvation counter 0; latency counter 0.
  - All outputs 0, including rdata and address registers.
  - Reset mid-transaction drops the transaction; mem_rd/mem_wr fall immediately (asynchronously); no rvalid is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick the winner:
    - data wins if d_req=1, unless if_req=1 and starve==MAX_WAIT;
    - else fetch wins.
  - gnt is combinational, asserted in the accept cycle T.
  - On the edge ending cycle T, latch addr, wdata, we and owner; go to ACCESS; load the latency counter with MEM_LAT-1.
- ACCESS, cycles T+1 .. T+MEM_LAT:
  - mem_addr and mem_wdata driven from latches; mem_rd = ~we; mem_wr = we. Fetch is always a read.
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata on that edge and go to RESP.
- RESP, cycle T+MEM_LAT+1:
  - The owner's rvalid = 1 and the registered rdata is presented.
  - mem_rd = mem_wr = 0.
  - Next state is IDLE. No new accept is possible in RESP.
  - Total latency from accept to rvalid is MEM_LAT+1 cycles. Peak throughput is one transaction per MEM_LAT+2 cycles.
- rdata hold: rdata holds its value until the next capture; the non-owner's rdata is unchanged.
- Fetch data selection: if_rdata = mem_rdata[31:0] when latched if_addr[2]=0, else mem_rdata[63:32].
- Starvation counter:
  - In an IDLE accept cycle where data wins while if_req=1: starve += 1, saturating at MAX_WAIT.
  - When fetch is granted, or in any IDLE cycle with if_req=0: starve = 0.
- Requester rules:
  - req and its addr/data stay stable until gnt.
  - Dropping req before gnt is a legal withdraw and leaves no side effect.
  - req held high in ACCESS/RESP is ignored; it is re-arbitrated in the next IDLE.
- Simultaneous req in IDLE: exactly one gnt. Never if_gnt and d_gnt in the same cycle.
- Misaligned addresses: low address bits are passed through unchanged; no error is flagged.

Decomposition:
- common.vh: `WORD, `INST_SIZE; state encodings ST_IDLE/ST_ACCESS/ST_RESP (2 bits); owner encoding OWN_IF=0, OWN_D=1.
- One natural sub-module, mem_lat_counter: loadable down-counter with a zero flag, reused by the future multicycle controller.

Test Plan:
- d_req=0, if_req=1, if_addr=0x104, mem_rdata=0xAAAA_BBBB_1111_2222, MEM_LAT=2 -> if_gnt at T; mem_rd=1 at T+1..T+2 with mem_addr=0x104; if_rvalid=1 at T+3 with if_rdata=0xAAAABBBB.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD -> mem_wr=1 for 2 cycles with mem_wdata=0xDEAD; d_rvalid pulse at T+3; mem_rd stays 0.
- Both requests held continuously, MAX_WAIT=3 -> grant order D, D, D, IF, D, D, D, IF; no cycle with both gnt.
- if_req raised at T and dropped at T+1 while a data access is in progress -> no if_gnt; starve returns to 0 in the next IDLE.
- rst_n driven low in the middle of the first ACCESS cycle -> mem_rd falls within the same cycle; no rvalid; after release with if_req=1, a grant occurs in the first cycle.
- Load at 0x8 returning 0x1234 followed by a fetch -> d_rdata stays 0x1234 after the fetch completes.
